// File: rtl/ref_clkgen_if.sv
// ref_clkgen_if: control and status bundle for the reference-tracking clock generator.
// Latency: none (wires only).
// Backpressure: none; all signals are levels.
// Ports: en, ref_clk, div_sel driven by the master side;
//        clk_out, ref_per, locked, ovf driven by the generator.
interface ref_clkgen_if #(
  parameter int NCH   = 2,
  parameter int CNT_W = 16
);
  logic               en;
  logic               ref_clk;
  logic [2*NCH-1:0]   div_sel;
  logic [NCH-1:0]     clk_out;
  logic [CNT_W-1:0]   ref_per;
  logic               locked;
  logic               ovf;

  modport master (
    output en, ref_clk, div_sel,
    input  clk_out, ref_per, locked, ovf
  );

  modport slave (
    input  en, ref_clk, div_sel,
    output clk_out, ref_per, locked, ovf
  );
endinterface

// File: rtl/ref_clkgen.sv
// ref_clkgen: measures the reference period in clk cycles and generates NCH clocks
// at MULT x f(ref) / 2^div_sel, with a lock-detect state machine.
// Latency: ref edge -> ref_rise 3 clk; ref_rise -> ref_per/state/locked 1 clk.
// Backpressure: none; outputs are free-running levels.
// Ports: clk, resetn (async active-low); bus.en, bus.ref_clk, bus.div_sel in;
//        bus.clk_out, bus.ref_per, bus.locked, bus.ovf out.
module ref_clkgen #(
  parameter int MULT        = 8,
  parameter int CNT_W       = 16,
  parameter int NCH         = 2,
  parameter int LOCK_CNT    = 4,
  parameter int TOL         = 2,
  parameter int PHASE_ALIGN = 0
) (
  input  logic        clk,
  input  logic        resetn,
  ref_clkgen_if.slave bus
);

  localparam int SH = $clog2(2 * MULT);
  localparam int LW = CNT_W + 3;
  localparam logic [CNT_W-1:0] TOL_V  = CNT_W'(TOL);
  localparam logic [3:0]       LOCK_V = 4'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE, LOCKED} state_t;

  state_t           state, state_nxt;
  logic             ref_s1, ref_s2, ref_s3, ref_rise;
  logic [CNT_W-1:0] cnt, ref_per, new_per, diff, half;
  logic [3:0]       match, match_inc;
  logic             prev_vld, ovf, close, ovf_evt, run, act_d, locked;
  logic [NCH-1:0]   clk_out;
  logic [LW-1:0]    ph      [NCH];
  logic [LW-1:0]    lim     [NCH];
  logic [LW-1:0]    cur_lim [NCH];
  logic [LW-1:0]    lim_use [NCH];

  // ref is asynchronous: two sync flops, a history flop, then a registered edge pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ref_s1   <= 1'b0;
      ref_s2   <= 1'b0;
      ref_s3   <= 1'b0;
      ref_rise <= 1'b0;
    end else begin
      ref_s1   <= bus.ref_clk;
      ref_s2   <= ref_s1;
      ref_s3   <= ref_s2;
      ref_rise <= ref_s2 & ~ref_s3;
    end
  end

  assign run       = (state == MEASURE) || (state == LOCKED);
  assign ovf_evt   = bus.en && run && (cnt == '1);
  assign new_per   = cnt + CNT_W'(1);
  // ref_per doubles as the previous period for the stability comparison
  assign diff      = (new_per >= ref_per) ? (new_per - ref_per) : (ref_per - new_per);
  assign close     = prev_vld && (diff <= TOL_V);
  assign match_inc = match + 4'd1;
  assign half      = ref_per >> SH;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    if (!bus.en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = ACQUIRE;
        ACQUIRE: if (ref_rise) state_nxt = MEASURE;
        MEASURE: begin
          if (ovf_evt)                                     state_nxt = ACQUIRE;
          else if (ref_rise && close && match_inc >= LOCK_V) state_nxt = LOCKED;
        end
        LOCKED: begin
          if (ovf_evt)                state_nxt = ACQUIRE;
          else if (ref_rise && !close) state_nxt = MEASURE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  // a too-fast reference (half == 0) never reports lock
  always_comb begin
    locked = 1'b0;
    if (state == LOCKED && half != '0) locked = 1'b1;
  end

  // Period counter and match tracking
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt      <= '0;
      ref_per  <= '0;
      match    <= '0;
      prev_vld <= 1'b0;
      ovf      <= 1'b0;
    end else if (!bus.en) begin
      cnt      <= '0;
      match    <= '0;
      prev_vld <= 1'b0;
      ovf      <= 1'b0;
    end else if (ovf_evt) begin
      // stale period after a saturation: restart acquisition from scratch
      cnt      <= '0;
      match    <= '0;
      prev_vld <= 1'b0;
      ovf      <= 1'b1;
    end else if (run) begin
      if (ref_rise) begin
        cnt      <= '0;
        ref_per  <= new_per;
        prev_vld <= 1'b1;
        if (!close)             match <= '0;
        else if (match < LOCK_V) match <= match_inc;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  // Terminal counts; a freshly started channel uses the live value, a running one
  // keeps its latched limit until its own wrap so no runt half-period appears.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cur_lim[i] = {3'b000, half} << bus.div_sel[2*i +: 2];
      lim_use[i] = act_d ? lim[i] : cur_lim[i];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_out <= '0;
      act_d   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        ph[i]  <= '0;
        lim[i] <= '0;
      end
    end else if (!bus.en || !run || ovf_evt) begin
      clk_out <= '0;
      act_d   <= 1'b0;
      for (int i = 0; i < NCH; i++) ph[i] <= '0;
    end else if (half == '0) begin
      // reference too fast: freeze outputs at their current level
      act_d <= 1'b0;
      for (int i = 0; i < NCH; i++) ph[i] <= '0;
    end else if (PHASE_ALIGN != 0 && state == LOCKED && ref_rise) begin
      // alignment wins over a coincident wrap
      act_d   <= 1'b1;
      clk_out <= '1;
      for (int i = 0; i < NCH; i++) begin
        ph[i]  <= '0;
        lim[i] <= cur_lim[i];
      end
    end else begin
      act_d <= 1'b1;
      for (int i = 0; i < NCH; i++) begin
        if (ph[i] == lim_use[i] - LW'(1)) begin
          ph[i]      <= '0;
          lim[i]     <= cur_lim[i];
          clk_out[i] <= ~clk_out[i];
        end else begin
          ph[i]  <= ph[i] + LW'(1);
          lim[i] <= lim_use[i];
        end
      end
    end
  end

  assign bus.clk_out = clk_out;
  assign bus.ref_per = ref_per;
  assign bus.locked  = locked;
  assign bus.ovf     = ovf;

endmodule

// File: tb/tb_ref_clkgen.sv
// tb_ref_clkgen: directed bench for ref_clkgen (MULT 8, CNT_W 8, NCH 2, LOCK_CNT 4, TOL 2).
// Latency: n/a.
// Backpressure: n/a.
module tb_ref_clkgen;
  localparam int CNT_W = 8;
  localparam int NCH   = 2;

  logic clk;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  int   ref_base = 0;
  int   ref_edges = 0;
  int   per_q[$];
  int   exp_per[5] = '{80, 82, 80, 82, 80};

  ref_clkgen_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

  ref_clkgen #(
    .MULT(8), .CNT_W(CNT_W), .NCH(NCH), .LOCK_CNT(4), .TOL(2), .PHASE_ALIGN(0)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference source: each period length (in clk) is taken from per_q if queued,
  // otherwise ref_base; 0 stops the reference low.
  initial begin : refgen
    int cur;
    int ph;
    cur = 0;
    ph  = 0;
    bus.ref_clk = 1'b0;
    forever begin
      @(negedge clk);
      if (ph == 0) begin
        cur = (per_q.size() > 0) ? per_q.pop_front() : ref_base;
        if (cur != 0) begin
          bus.ref_clk = 1'b1;
          ref_edges++;
        end else begin
          bus.ref_clk = 1'b0;
        end
      end else if (ph == cur / 2) begin
        bus.ref_clk = 1'b0;
      end
      ph = (cur == 0 || ph + 1 == cur) ? 0 : ph + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns on the first posedge after the next reference rising edge.
  task automatic wait_edge();
    int start;
    int n;
    start = ref_edges;
    n = 0;
    while (ref_edges == start && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (ref_edges == start) begin
      checks++;
      errors++;
      $error("FAIL ref_edge_timeout: observed no edge expected edge within 400 clk");
    end
  endtask

  // Counts sampled clk cycles until clk_out[ch] changes level.
  task automatic wait_toggle(input int ch, output int n);
    logic v;
    v = bus.clk_out[ch];
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.clk_out[ch] === v && n < 400);
  endtask

  // From en = 0: enable just after a ref edge, then lock must appear 4 clk after edge 6.
  task automatic relock(input string tag);
    ref_base = 80;
    wait_edge();
    repeat (4) @(posedge clk);
    #1;
    bus.en = 1'b1;
    repeat (5) wait_edge();
    wait_edge();
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_lock_early"}, bus.locked, 1'b0);
    @(posedge clk);
    #1;
    check({tag, "_lock"}, bus.locked, 1'b1);
    check({tag, "_per"}, bus.ref_per, 80);
  endtask

  initial begin : main
    int a;
    int b;
    int n;

    resetn      = 1'b0;
    bus.en      = 1'b0;
    bus.div_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_clk_out", bus.clk_out, 2'b00);
    check("rst_ref_per", bus.ref_per, 0);
    check("rst_locked", bus.locked, 1'b0);
    check("rst_ovf", bus.ovf, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

    // Basic lock: 80-clk reference, ch0 div 1, ch1 div 4
    @(posedge clk);
    #1;
    bus.div_sel = {2'd2, 2'd0};
    bus.en      = 1'b1;
    ref_base    = 80;
    repeat (5) wait_edge();
    repeat (3) @(posedge clk);
    #1;
    check("lock_edge5", bus.locked, 1'b0);
    wait_edge();
    repeat (2) @(posedge clk);
    #1;
    check("lock_edge6_3clk", bus.locked, 1'b0);
    @(posedge clk);
    #1;
    check("lock_edge6_4clk", bus.locked, 1'b1);
    check("basic_ref_per", bus.ref_per, 80);

    wait_toggle(0, n);
    wait_toggle(0, a);
    wait_toggle(0, b);
    check("ch0_high_or_low", a, 5);
    check("ch0_period_ns", (a + b) * 10, 100);
    wait_toggle(1, n);
    wait_toggle(1, a);
    wait_toggle(1, b);
    check("ch1_period_ns", (a + b) * 10, 400);

    // div_sel change mid half-period: current half finishes at 20, then 10
    wait_toggle(1, n);
    repeat (5) @(posedge clk);
    #1;
    bus.div_sel = {2'd1, 2'd0};
    wait_toggle(1, a);
    check("div_chg_remaining", a, 15);
    wait_toggle(1, b);
    check("div_chg_new_half", b, 10);

    // Jitter: alternating 82/80 stays locked
    wait_edge();
    per_q.push_back(82);
    per_q.push_back(80);
    per_q.push_back(82);
    per_q.push_back(80);
    for (int k = 0; k < 5; k++) begin
      wait_edge();
      repeat (3) @(posedge clk);
      #1;
      check("jit_locked", bus.locked, 1'b1);
      check("jit_ref_per", bus.ref_per, exp_per[k]);
    end

    // One 90-clk period breaks lock; relock after 4 matching periods
    per_q.push_back(90);
    wait_edge();
    wait_edge();
    repeat (2) @(posedge clk);
    #1;
    check("p90_before_rise", bus.locked, 1'b1);
    @(posedge clk);
    #1;
    check("p90_unlock", bus.locked, 1'b0);
    check("p90_ref_per", bus.ref_per, 90);
    repeat (4) wait_edge();
    repeat (3) @(posedge clk);
    #1;
    check("p90_match3", bus.locked, 1'b0);
    wait_edge();
    repeat (2) @(posedge clk);
    #1;
    check("p90_relock_early", bus.locked, 1'b0);
    @(posedge clk);
    #1;
    check("p90_relock", bus.locked, 1'b1);

    // Overflow: reference stops after this edge; cnt saturates 256 clk after its ref_rise
    wait_edge();
    ref_base = 0;
    repeat (258) @(posedge clk);
    #1;
    check("ovf_before", bus.ovf, 1'b0);
    @(posedge clk);
    #1;
    check("ovf_set", bus.ovf, 1'b1);
    check("ovf_clk_out", bus.clk_out, 2'b00);
    check("ovf_locked", bus.locked, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("ovf_sticky", bus.ovf, 1'b1);
    check("ovf_clk_out_low", bus.clk_out, 2'b00);
    bus.en      = 1'b0;
    bus.div_sel = '0;
    @(posedge clk);
    #1;
    check("ovf_clear", bus.ovf, 1'b0);
    check("ovf_ref_per_held", bus.ref_per, 80);

    // Too-fast reference: 10 clk -> half 0, outputs frozen low, never locked
    bus.en   = 1'b1;
    ref_base = 10;
    repeat (10) wait_edge();
    repeat (3) @(posedge clk);
    #1;
    check("fast_ref_per", bus.ref_per, 10);
    check("fast_locked", bus.locked, 1'b0);
    check("fast_clk_out", bus.clk_out, 2'b00);
    repeat (30) @(posedge clk);
    #1;
    check("fast_clk_out_frozen", bus.clk_out, 2'b00);
    check("fast_locked_later", bus.locked, 1'b0);

    bus.en = 1'b0;
    relock("en_relock");

    // en dropped while locked
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    check("endrop_locked", bus.locked, 1'b0);
    check("endrop_clk_out", bus.clk_out, 2'b00);
    check("endrop_ref_per", bus.ref_per, 80);
    relock("en2_relock");

    // Asynchronous reset mid-cycle
    #3;
    resetn = 1'b0;
    #1;
    check("arst_ref_per", bus.ref_per, 0);
    check("arst_locked", bus.locked, 1'b0);
    check("arst_clk_out", bus.clk_out, 2'b00);
    check("arst_ovf", bus.ovf, 1'b0);
    bus.en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    relock("rst_relock");

    wait_toggle(0, n);
    wait_toggle(0, a);
    wait_toggle(0, b);
    check("final_ch0_period", a + b, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
